// File: rtl/bf_loop_ctrl.sv
// Loop controller for a Brainfuck core: tracks '[' / ']' nesting, requests back-jumps and forward-skips.
// Optional taken-jump counter on loop_count is built only when BF_LOOP_STATS_EN is defined.
module bf_loop_ctrl #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            clr,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_open,
  input  logic            op_close,
  input  logic [PC_W-1:0] op_pc,
  input  logic            cell_zero,
  output logic            skip,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            err,
  output logic [4:0]      depth,
  output logic [15:0]     loop_count
);

  localparam int         AW   = $clog2(STACK_DEPTH);
  localparam logic [4:0] FULL = 5'(STACK_DEPTH);

  typedef enum logic [1:0] {RUN, SKIP, ERROR} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      depth_reg, depth_next;
  logic [7:0]      skip_cnt_reg, skip_cnt_next;
  logic            skip_reg, skip_next;
  logic            pc_load_reg, pc_load_next;
  logic            err_reg, err_next;
  logic [PC_W-1:0] pc_target_reg, pc_target_next;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic            push;
  logic            hs, is_open, is_close;
  logic [AW-1:0]   push_idx, top_idx;

  assign op_ready = ena && (state_reg != ERROR);
  assign hs       = op_valid && op_ready;
  assign is_open  = op_open && !op_close;
  assign is_close = op_close && !op_open;
  assign push_idx = depth_reg[AW-1:0];
  assign top_idx  = AW'(depth_reg - 5'd1);

  always_comb begin
    state_next     = state_reg;
    depth_next     = depth_reg;
    skip_cnt_next  = skip_cnt_reg;
    err_next       = err_reg;
    pc_target_next = pc_target_reg;
    pc_load_next   = 1'b0;
    push           = 1'b0;
    if (clr) begin
      state_next     = RUN;
      depth_next     = 5'd0;
      skip_cnt_next  = 8'd0;
      err_next       = 1'b0;
      pc_target_next = '0;
    end else if (hs) begin
      unique case (state_reg)
        RUN: begin
          if (is_open) begin
            if (depth_reg == FULL) begin
              state_next = ERROR;
              err_next   = 1'b1;
            end else if (cell_zero) begin
              skip_cnt_next = 8'd1;
              state_next    = SKIP;
            end else begin
              push       = 1'b1;
              depth_next = depth_reg + 5'd1;
            end
          end else if (is_close) begin
            if (depth_reg == 5'd0) begin
              state_next = ERROR;
              err_next   = 1'b1;
            end else if (!cell_zero) begin
              // Loop body repeats: jump to the instruction after the matching '['.
              pc_load_next   = 1'b1;
              pc_target_next = stack_mem[top_idx] + PC_W'(1);
            end else begin
              depth_next = depth_reg - 5'd1;
            end
          end
        end
        SKIP: begin
          if (is_open) begin
            if (skip_cnt_reg == 8'hFF) begin
              state_next = ERROR;
              err_next   = 1'b1;
            end else begin
              skip_cnt_next = skip_cnt_reg + 8'd1;
            end
          end else if (is_close) begin
            if (skip_cnt_reg == 8'd1) begin
              skip_cnt_next = 8'd0;
              state_next    = RUN;
            end else begin
              skip_cnt_next = skip_cnt_reg - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
    skip_next = (state_next == SKIP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      depth_reg     <= 5'd0;
      skip_cnt_reg  <= 8'd0;
      skip_reg      <= 1'b0;
      pc_load_reg   <= 1'b0;
      pc_target_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      depth_reg     <= depth_next;
      skip_cnt_reg  <= skip_cnt_next;
      skip_reg      <= skip_next;
      pc_load_reg   <= pc_load_next;
      pc_target_reg <= pc_target_next;
      err_reg       <= err_next;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by depth_reg alone.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= op_pc;
  end

  assign skip      = skip_reg;
  assign pc_load   = pc_load_reg;
  assign pc_target = pc_target_reg;
  assign err       = err_reg;
  assign depth     = depth_reg;

`ifdef BF_LOOP_STATS_EN
  logic [15:0] loop_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_count_reg <= 16'd0;
    end else if (clr) begin
      loop_count_reg <= 16'd0;
    end else if (pc_load_reg && (loop_count_reg != 16'hFFFF)) begin
      loop_count_reg <= loop_count_reg + 16'd1;
    end
  end

  assign loop_count = loop_count_reg;
`else
  assign loop_count = 16'd0;
`endif

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Directed bench for bf_loop_ctrl: expected post-handshake outputs are queued per instruction and checked one cycle later.
module tb_bf_loop_ctrl;

  logic        clk, rst_n, ena, clr, op_valid, op_ready, op_open, op_close, cell_zero;
  logic        skip, pc_load, err;
  logic [7:0]  op_pc, pc_target;
  logic [4:0]  depth;
  logic [15:0] loop_count;

`ifdef BF_LOOP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       pl;
    logic [7:0] tgt;
    logic       sk;
    logic       er;
    logic [4:0] dp;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  bf_loop_ctrl #(.PC_W(8), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .op_valid(op_valid), .op_ready(op_ready), .op_open(op_open), .op_close(op_close),
    .op_pc(op_pc), .cell_zero(cell_zero), .skip(skip), .pc_load(pc_load),
    .pc_target(pc_target), .err(err), .depth(depth), .loop_count(loop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present one instruction for one clock, then compare against the queued expectation.
  task automatic issue(input string tag, input logic o, input logic c, input logic [7:0] pc,
                       input logic cz, input logic pl, input logic [7:0] tgt,
                       input logic sk, input logic er, input logic [4:0] dp);
    exp_t e;
    sb.push_back('{tag: tag, pl: pl, tgt: tgt, sk: sk, er: er, dp: dp});
    op_valid = 1'b1; op_open = o; op_close = c; op_pc = pc; cell_zero = cz;
    @(posedge clk); #1;
    op_valid = 1'b0; op_open = 1'b0; op_close = 1'b0;
    e = sb.pop_front();
    $display("op %s pc=%0d -> pc_load=%0b tgt=%0d skip=%0b err=%0b depth=%0d",
             e.tag, pc, pc_load, pc_target, skip, err, depth);
    chk({e.tag, ".pc_load"}, 32'(pc_load), 32'(e.pl));
    if (e.pl) chk({e.tag, ".pc_target"}, 32'(pc_target), 32'(e.tgt));
    chk({e.tag, ".skip"}, 32'(skip), 32'(e.sk));
    chk({e.tag, ".err"}, 32'(err), 32'(e.er));
    chk({e.tag, ".depth"}, 32'(depth), 32'(e.dp));
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1; op_valid = 1'b1; op_open = 1'b1; op_close = 1'b0; op_pc = 8'd9; cell_zero = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; op_valid = 1'b0; op_open = 1'b0;
    $display("clr %s -> err=%0b depth=%0d skip=%0b ready=%0b", tag, err, depth, skip, op_ready);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".depth"}, 32'(depth), 32'd0);
    chk({tag, ".skip"}, 32'(skip), 32'd0);
    chk({tag, ".ready"}, 32'(op_ready), 32'd1);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    $display("idle %s -> pc_load=%0b", tag, pc_load);
    chk({tag, ".pc_load"}, 32'(pc_load), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; op_valid = 1'b0;
    op_open = 1'b0; op_close = 1'b0; op_pc = 8'd0; cell_zero = 1'b0;
    #1;
    chk("rst.skip", 32'(skip), 32'd0);
    chk("rst.pc_load", 32'(pc_load), 32'd0);
    chk("rst.pc_target", 32'(pc_target), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.depth", 32'(depth), 32'd0);
    chk("rst.loop_count", 32'(loop_count), 32'd0);
    chk("rst.ready", 32'(op_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-jump taken, then loop exit
    issue("open3", 1, 0, 8'd3, 0, 0, 8'd0, 0, 0, 5'd1);
    issue("close7_jump", 0, 1, 8'd7, 0, 1, 8'd4, 0, 0, 5'd1);
    idle("after_jump");
    issue("close7_exit", 0, 1, 8'd7, 1, 0, 8'd0, 0, 0, 5'd0);

    // Forward skip with nesting
    issue("skip_open2", 1, 0, 8'd2, 1, 0, 8'd0, 1, 0, 5'd0);
    issue("skip_nest", 1, 0, 8'd3, 0, 0, 8'd0, 1, 0, 5'd0);
    issue("skip_close1", 0, 1, 8'd4, 0, 0, 8'd0, 1, 0, 5'd0);
    issue("skip_close2", 0, 1, 8'd5, 0, 0, 8'd0, 0, 0, 5'd0);

    // ena=0 mid-scan freezes the scan
    issue("skip_open_ena", 1, 0, 8'd6, 1, 0, 8'd0, 1, 0, 5'd0);
    ena = 1'b0; op_valid = 1'b1; op_close = 1'b1;
    #1 chk("ena0.ready", 32'(op_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ena0.skip", 32'(skip), 32'd1);
    chk("ena0.pc_load", 32'(pc_load), 32'd0);
    ena = 1'b1; op_valid = 1'b0; op_close = 1'b0;
    issue("skip_close_ena", 0, 1, 8'd8, 0, 0, 8'd0, 0, 0, 5'd0);

    // Fill the stack, jump from the top, overflow on the ninth '['
    for (int i = 0; i < 8; i++)
      issue($sformatf("fill%0d", i), 1, 0, 8'(10 + i), 0, 0, 8'd0, 0, 0, 5'(i + 1));
    issue("close_top", 0, 1, 8'd30, 0, 1, 8'd18, 0, 0, 5'd8);
    issue("overflow", 1, 0, 8'd18, 0, 0, 8'd0, 0, 1, 5'd8);
    chk("overflow.ready", 32'(op_ready), 32'd0);
    idle("err_sticky");
    chk("err_sticky.err", 32'(err), 32'd1);
    do_clr("clr_overflow");

    // Underflow
    issue("underflow", 0, 1, 8'd1, 0, 0, 8'd0, 0, 1, 5'd0);
    do_clr("clr_underflow");

    // Target wraps modulo 2^PC_W; ignored encodings have no effect
    issue("open255", 1, 0, 8'd255, 0, 0, 8'd0, 0, 0, 5'd1);
    issue("both_high", 1, 1, 8'd0, 0, 0, 8'd0, 0, 0, 5'd1);
    issue("both_low", 0, 0, 8'd1, 1, 0, 8'd0, 0, 0, 5'd1);
    issue("close_wrap", 0, 1, 8'd2, 0, 1, 8'd0, 0, 0, 5'd1);
    issue("close_pop", 0, 1, 8'd2, 1, 0, 8'd0, 0, 0, 5'd0);

    // Skip nesting counter overflow
    issue("deep0", 1, 0, 8'd0, 1, 0, 8'd0, 1, 0, 5'd0);
    for (int i = 1; i < 255; i++)
      issue($sformatf("deep%0d", i), 1, 0, 8'(i), 0, 0, 8'd0, 1, 0, 5'd0);
    issue("deep_over", 1, 0, 8'd255, 0, 0, 8'd0, 0, 1, 5'd0);
    do_clr("clr_deep");

    // Async reset during a scan with skip_cnt=3
    issue("ar_open0", 1, 0, 8'd1, 1, 0, 8'd0, 1, 0, 5'd0);
    issue("ar_open1", 1, 0, 8'd2, 0, 0, 8'd0, 1, 0, 5'd0);
    issue("ar_open2", 1, 0, 8'd3, 0, 0, 8'd0, 1, 0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async.skip", 32'(skip), 32'd0);
    chk("async.depth", 32'(depth), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue("post_rst_open5", 1, 0, 8'd5, 0, 0, 8'd0, 0, 0, 5'd1);
    issue("post_rst_close", 0, 1, 8'd9, 0, 1, 8'd6, 0, 0, 5'd1);

    // Taken back-jump statistics
    do_clr("clr_stats");
    chk("stats.cleared", 32'(loop_count), 32'd0);
    issue("stats_open3", 1, 0, 8'd3, 0, 0, 8'd0, 0, 0, 5'd1);
    for (int i = 0; i < 300; i++)
      issue($sformatf("jump%0d", i), 0, 1, 8'd7, 0, 1, 8'd4, 0, 0, 5'd1);
    idle("stats_tail");
    chk("stats.loop_count", 32'(loop_count), STATS ? 32'd300 : 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bf_loop_ctrl.md
BF_LOOP_CTRL -- requirements
Module: bf_loop_ctrl

Interface
REQ-001 Parameter PC_W, default 8: program-counter width in bits.
REQ-002 Parameter STACK_DEPTH, default 8: loop-stack entries, power of two, from 2 to 16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; low freezes all state and forces op_ready=0.
REQ-006 clr  input  1  synchronous soft clear to the reset state; has priority over op handling.
REQ-007 op_valid  input  1  decoded instruction present.
REQ-008 op_ready  output  1  instruction accepted this cycle when op_valid=1.
REQ-009 op_open  input  1  instruction is '['.
REQ-010 op_close  input  1  instruction is ']'.
REQ-011 op_pc  input  PC_W  address of the presented instruction.
REQ-012 cell_zero  input  1  current tape cell equals 0, sampled at acceptance.
REQ-013 skip  output  1  registered; 1 while forward-scanning, so the datapath suppresses execution.
REQ-014 pc_load  output  1  registered one-cycle pulse requesting a PC jump.
REQ-015 pc_target  output  PC_W  jump address, valid while pc_load=1.
REQ-016 err  output  1  sticky fault flag.
REQ-017 depth  output  5  current loop-stack occupancy.
REQ-018 loop_count  output  16  taken back-jump count (see Configuration).

Function
REQ-019 A handshake occurs when op_valid=1, op_ready=1 and ena=1 on a rising edge; op_ready = ena and (state != ERROR).
REQ-020 The states are RUN, SKIP and ERROR.
REQ-021 An instruction with op_open=op_close=1, or with both low, is accepted with no effect.
REQ-022 RUN, '[' with cell_zero=0: push op_pc, stay in RUN.
REQ-023 RUN, '[' with cell_zero=1: no push, skip_cnt<=1, go to SKIP; skip=1 from the next cycle.
REQ-024 RUN, ']' with cell_zero=0 and depth>0: no pop.
REQ-025 For the REQ-024 case, the next cycle has pc_load=1 and pc_target = top+1 (mod 2^PC_W).
REQ-026 RUN, ']' with cell_zero=1 and depth>0: pop, no jump.
REQ-027 RUN, '[' with depth=STACK_DEPTH, or ']' with depth=0: go to ERROR, err<=1, stack unchanged.
REQ-028 SKIP: every handshaked instruction is accepted.
REQ-029 SKIP counting: '[' increments skip_cnt (8 bit), and ']' decrements it.
REQ-030 SKIP exit: ']' with skip_cnt=1 returns to RUN, and skip falls the following cycle.
REQ-031 SKIP, '[' with skip_cnt=255: go to ERROR.
REQ-032 The stack is not modified in SKIP.
REQ-033 ERROR is left only by clr or reset.
REQ-034 pc_load is never high on two consecutive cycles without an intervening handshake; latency is exactly 1 cycle from the handshake.
REQ-035 ena=0 mid-scan holds skip, skip_cnt, stack and state, with pc_load forced 0.

Reset
REQ-036 On rst_n=0, immediately: state=RUN, depth=0, skip_cnt=0, skip=0, pc_load=0, pc_target=0, err=0, loop_count=0.
REQ-037 clr=1 produces the same values on the next edge, and any instruction presented with clr=1 is discarded.
REQ-038 Stack contents need not be reset.

Configuration
REQ-039 Macro BF_LOOP_STATS_EN defined: loop_count increments on each pc_load pulse, saturates at 16'hFFFF, and is cleared by reset and clr.
REQ-040 Macro BF_LOOP_STATS_EN undefined: the loop_count port remains and is tied to 0, and no counter logic is synthesized.

Verification
REQ-041 ']' cases: push '[' at pc 3 (cell_zero=0), then ']' at pc 7 with cell_zero=0 -> next cycle pc_load=1, pc_target=4, depth stays 1; repeat with cell_zero=1 -> no pc_load, depth=0.
REQ-042 '[' at pc 2 with cell_zero=1 -> skip=1; then '[' , ']' , ']' -> skip=0 one cycle after the third instruction, depth=0, no pc_load.
REQ-043 Nine '[' with cell_zero=0 and STACK_DEPTH=8 -> err=1 after the ninth, op_ready=0, depth=8; then clr=1 -> err=0, depth=0, op_ready=1.
REQ-044 Stack-underflow error: ']' with depth=0 -> err=1.
REQ-045 Asynchronous reset mid-operation: during SKIP with skip_cnt=3, assert rst_n=0 between edges -> skip=0 with no clock edge; after release, '[' at pc 5 is handled in RUN.
REQ-046 With BF_LOOP_STATS_EN, 300 taken back-jumps -> loop_count=300; without the macro -> loop_count=0 throughout.
